mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter_burst_addr_gen.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared defaults and enums for the CPU/video RAM port arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int c_ADDR_W  = 17;
    localparam int c_DATA_W  = 24;
    localparam int c_MAX_RUN = 4;
    localparam int c_LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_ACC   = 2'd1,
        VID_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : CPU, video and RAM-side signals of the port arbiter
// Revision            : 1.0
// ============================================================================
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) ();

    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic                cpu_gnt;
    logic                cpu_rvalid;
    logic [DATA_W-1:0]   cpu_rdata;

    logic                vid_req;
    logic [ADDR_W-1:0]   vid_addr;
    logic [c_LEN_W-1:0]  vid_len;
    logic                vid_gnt;
    logic                vid_rvalid;
    logic [DATA_W-1:0]   vid_rdata;
    logic                vid_done;

    logic                ram_en;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_req, vid_addr, vid_len,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output vid_gnt, vid_rvalid, vid_rdata, vid_done,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requesters and RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_req, vid_addr, vid_len,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata, vid_done,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// burst_addr_gen : video burst base/length latch, beat counter and wrapping address
// Revision       : 1.0
// ============================================================================
module burst_addr_gen
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_start,
    input  wire logic                i_advance,
    input  wire logic [ADDR_W-1:0]   i_base,
    input  wire logic [c_LEN_W-1:0]  i_len,
    output logic      [ADDR_W-1:0]   o_addr,
    output logic                     o_last
);

    logic [ADDR_W-1:0]   r_base;
    logic [c_LEN_W-1:0]  r_len;
    logic [c_LEN_W-1:0]  r_cnt;

    // Beat 0 is issued in the same cycle the burst is accepted, so it is
    // served straight from the request inputs while they are being latched.
    always_comb begin
        if (i_start) begin
            o_addr = i_base;
            o_last = (i_len == '0);
        end else begin
            o_addr = r_base + ADDR_W'(r_cnt);
            o_last = (r_cnt == r_len);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (i_advance) begin
            if (i_start) begin
                r_base <= i_base;
                r_len  <= i_len;
                r_cnt  <= c_LEN_W'(1);
            end else begin
                r_cnt  <= r_cnt + c_LEN_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : single-port RAM arbiter between CPU word accesses and video bursts
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W,
    parameter int MAX_RUN = c_MAX_RUN
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int c_RUN_W = (MAX_RUN < 2) ? 1 : $clog2(MAX_RUN);

    arb_state_t          r_state;
    owner_t              r_last_owner;
    logic                r_burst_pend;
    logic [c_RUN_W-1:0]  r_run;
    logic                r_rd_valid;
    owner_t              r_rd_owner;
    logic                r_rd_last;

    arb_state_t          w_next;
    logic                w_cpu_sel;
    logic                w_vid_sel;
    logic                w_start;
    logic                w_run_hit;
    logic [ADDR_W-1:0]   w_gen_addr;
    logic                w_gen_last;
    logic                w_cpu_rv;
    logic                w_vid_rv;

    burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_burst_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_advance (w_vid_sel),
        .i_base    (bus.vid_addr),
        .i_len     (bus.vid_len),
        .o_addr    (w_gen_addr),
        .o_last    (w_gen_last)
    );

    // Grant decision for the current cycle; everything is forced off in reset.
    always_comb begin
        w_cpu_sel = 1'b0;
        w_vid_sel = 1'b0;
        w_start   = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_req && (!bus.vid_req || r_last_owner == OWN_VID)) begin
                        w_cpu_sel = 1'b1;
                    end else if (bus.vid_req) begin
                        w_vid_sel = 1'b1;
                        w_start   = 1'b1;
                    end
                end
                CPU_ACC:   w_cpu_sel = bus.cpu_req;
                VID_BURST: w_vid_sel = 1'b1;
                default:   ;
            endcase
        end
    end

    assign w_run_hit = bus.cpu_req && (r_run == c_RUN_W'(MAX_RUN - 1));

    always_comb begin
        w_next = IDLE;
        if (w_vid_sel) begin
            if (w_gen_last) begin
                w_next = bus.cpu_req ? CPU_ACC : IDLE;
            end else if (w_run_hit) begin
                w_next = CPU_ACC;
            end else begin
                w_next = VID_BURST;
            end
        end else if (r_burst_pend) begin
            w_next = VID_BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_VID;
            r_burst_pend <= 1'b0;
            r_run        <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_owner   <= OWN_CPU;
            r_rd_last    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cpu_sel) begin
                r_last_owner <= OWN_CPU;
                r_run        <= '0;
            end else if (w_vid_sel) begin
                r_last_owner <= OWN_VID;
                // Only an unbroken run of beats with the CPU waiting counts.
                r_run <= (w_run_hit || w_gen_last || !bus.cpu_req) ? '0
                                                                    : r_run + c_RUN_W'(1);
            end
            if (w_vid_sel) begin
                r_burst_pend <= !w_gen_last;
            end
            r_rd_valid <= (w_cpu_sel && !bus.cpu_we) || w_vid_sel;
            r_rd_owner <= w_vid_sel ? OWN_VID : OWN_CPU;
            r_rd_last  <= w_vid_sel && w_gen_last;
        end
    end

    assign w_cpu_rv = !rst && r_rd_valid && (r_rd_owner == OWN_CPU);
    assign w_vid_rv = !rst && r_rd_valid && (r_rd_owner == OWN_VID);

    assign bus.cpu_gnt    = w_cpu_sel;
    assign bus.vid_gnt    = w_vid_sel;
    assign bus.ram_en     = w_cpu_sel || w_vid_sel;
    assign bus.ram_we     = w_cpu_sel && bus.cpu_we;
    assign bus.ram_addr   = w_cpu_sel ? bus.cpu_addr : (w_vid_sel ? w_gen_addr : '0);
    assign bus.ram_wdata  = (w_cpu_sel && bus.cpu_we) ? bus.cpu_wdata : '0;

    assign bus.cpu_rvalid = w_cpu_rv;
    assign bus.cpu_rdata  = w_cpu_rv ? bus.ram_rdata : '0;
    assign bus.vid_rvalid = w_vid_rv;
    assign bus.vid_rdata  = w_vid_rv ? bus.ram_rdata : '0;
    assign bus.vid_done   = w_vid_rv && r_rd_last;

endmodule
`default_nettype wire
